// File: rtl/pair_index_sequencer.sv
// Index-pair responder for the pipeline controller: walks every (A,B) point pair with
// A ascending and B descending from N_POINTS-1 to A+1, and counts the results written back.
module pair_index_sequencer #(
    parameter int IDX_W    = 9,
    parameter int N_POINTS = 16,
    parameter int CNT_W    = 18
) (
    input  logic             clk,
    input  logic             start,
    input  logic             clear_Pipes,
    input  logic [1:0]       p1_En,
    input  logic             out_En,
    output logic [IDX_W-1:0] A_new,
    output logic [IDX_W-1:0] B_new,
    output logic [IDX_W-1:0] A_old,
    output logic             pair_valid,
    output logic             last_pair,
    output logic [CNT_W-1:0] result_count,
    output logic             all_done
);

    typedef enum logic [1:0] {IDLE, RUN, EXHAUSTED, DONE} state_t;

    localparam logic [IDX_W-1:0] B_FIRST = IDX_W'(N_POINTS - 1);
    localparam logic [IDX_W:0]   LAST_A  = (IDX_W+1)'(N_POINTS - 2);
    localparam logic [CNT_W-1:0] TOTAL   = CNT_W'(N_POINTS * (N_POINTS - 1) / 2);

    state_t           state, state_nx;
    logic [IDX_W-1:0] a_nx, b_nx, a_old_nx;
    logic             valid_nx, last_nx, done_nx;
    logic [CNT_W-1:0] cnt_nx, cnt_inc;
    logic [IDX_W:0]   a_ext, b_ext, a_plus1;
    logic             advance;

    assign advance = |p1_En;
    assign a_ext   = {1'b0, A_new};
    assign b_ext   = {1'b0, B_new};
    // Extended by one bit so A+1 cannot wrap at the top of the index range
    assign a_plus1 = a_ext + (IDX_W+1)'(1);
    assign cnt_inc = result_count + CNT_W'(1);

    always_comb begin
        state_nx = state;
        a_nx     = A_new;
        b_nx     = B_new;
        a_old_nx = A_old;
        valid_nx = pair_valid;
        cnt_nx   = result_count;
        done_nx  = all_done;

        if (start) begin
            state_nx = IDLE;
            a_nx     = '0;
            b_nx     = B_FIRST;
            a_old_nx = '0;
            valid_nx = 1'b0;
            cnt_nx   = '0;
            done_nx  = 1'b0;
        end else if (clear_Pipes) begin
            state_nx = RUN;
            a_nx     = '0;
            b_nx     = B_FIRST;
            a_old_nx = '0;
            valid_nx = 1'b1;
            cnt_nx   = '0;
            done_nx  = 1'b0;
        end else if (state == RUN || state == EXHAUSTED) begin
            if (state == RUN && advance) begin
                a_old_nx = A_new;
                if (b_ext > a_plus1) begin
                    b_nx = B_new - IDX_W'(1);
                end else if (a_ext < LAST_A) begin
                    a_nx = A_new + IDX_W'(1);
                    b_nx = B_FIRST;
                end else begin
                    valid_nx = 1'b0;
                    state_nx = EXHAUSTED;
                end
            end
            // Completion outranks exhaustion when both land on the same edge
            if (out_En && result_count != TOTAL) begin
                cnt_nx = cnt_inc;
                if (cnt_inc == TOTAL) begin
                    done_nx  = 1'b1;
                    state_nx = DONE;
                end
            end
        end

        last_nx = (state_nx == RUN) && ({1'b0, a_nx} == LAST_A) && (b_nx == B_FIRST);
    end

    always_ff @(posedge clk) begin
        state        <= state_nx;
        A_new        <= a_nx;
        B_new        <= b_nx;
        A_old        <= a_old_nx;
        pair_valid   <= valid_nx;
        last_pair    <= last_nx;
        result_count <= cnt_nx;
        all_done     <= done_nx;
    end

endmodule

// File: tb/tb_pair_index_sequencer.sv
// Scoreboard bench for pair_index_sequencer: a pair-list reference model queues the
// expected outputs each cycle and a monitor compares them against the DUT.
module tb_pair_index_sequencer;

    localparam int IDX_W    = 9;
    localparam int N_POINTS = 4;
    localparam int CNT_W    = 18;
    localparam int TOTAL    = N_POINTS * (N_POINTS - 1) / 2;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_EXH  = 2;
    localparam int M_DONE = 3;

    typedef struct {
        int a;
        int b;
        int aold;
        int valid;
        int last;
        int cnt;
        int done;
    } exp_t;

    logic             clk;
    logic             start;
    logic             clear_Pipes;
    logic [1:0]       p1_En;
    logic             out_En;
    logic [IDX_W-1:0] A_new, B_new, A_old;
    logic             pair_valid, last_pair, all_done;
    logic [CNT_W-1:0] result_count;

    exp_t sb[$];
    int   n_vectors;
    int   n_miscompares;

    int pa[TOTAL];
    int pb[TOTAL];
    int m_mode, m_p, m_aold, m_cnt, m_valid, m_done;

    pair_index_sequencer #(.IDX_W(IDX_W), .N_POINTS(N_POINTS), .CNT_W(CNT_W)) dut (
        .clk(clk), .start(start), .clear_Pipes(clear_Pipes), .p1_En(p1_En), .out_En(out_En),
        .A_new(A_new), .B_new(B_new), .A_old(A_old), .pair_valid(pair_valid),
        .last_pair(last_pair), .result_count(result_count), .all_done(all_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int act, input int exp);
        if (act != exp) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model works on the enumerated pair list and a position in it
    task automatic applyStimulus(input logic s, input logic c, input logic [1:0] p, input logic o);
        exp_t e;
        int   nm;
        start       = s;
        clear_Pipes = c;
        p1_En       = p;
        out_En      = o;
        if (s) begin
            m_mode = M_IDLE; m_p = 0; m_aold = 0; m_cnt = 0; m_valid = 0; m_done = 0;
        end else if (c) begin
            m_mode = M_RUN; m_p = 0; m_aold = 0; m_cnt = 0; m_valid = 1; m_done = 0;
        end else if (m_mode == M_RUN || m_mode == M_EXH) begin
            nm = m_mode;
            if (m_mode == M_RUN && p != 2'b00) begin
                m_aold = pa[m_p];
                if (m_p < TOTAL - 1) m_p++;
                else begin
                    m_valid = 0;
                    nm = M_EXH;
                end
            end
            if (o && m_cnt < TOTAL) begin
                m_cnt++;
                if (m_cnt == TOTAL) begin
                    m_done = 1;
                    nm = M_DONE;
                end
            end
            m_mode = nm;
        end
        @(posedge clk);
        #1;
        e.a     = pa[m_p];
        e.b     = pb[m_p];
        e.aold  = m_aold;
        e.valid = m_valid;
        e.last  = (m_mode == M_RUN && m_p == TOTAL - 1) ? 1 : 0;
        e.cnt   = m_cnt;
        e.done  = m_done;
        sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                n_vectors++;
                checkOutput("A_new",        32'(A_new),        e.a);
                checkOutput("B_new",        32'(B_new),        e.b);
                checkOutput("A_old",        32'(A_old),        e.aold);
                checkOutput("pair_valid",   32'(pair_valid),   e.valid);
                checkOutput("last_pair",    32'(last_pair),    e.last);
                checkOutput("result_count", 32'(result_count), e.cnt);
                checkOutput("all_done",     32'(all_done),     e.done);
            end
        end
    end

    initial begin : stimulus
        int k;
        int budget;
        n_vectors     = 0;
        n_miscompares = 0;
        k = 0;
        for (int a = 0; a <= N_POINTS - 2; a++)
            for (int b = N_POINTS - 1; b > a; b--) begin
                pa[k] = a;
                pb[k] = b;
                k++;
            end
        m_mode = M_IDLE; m_p = 0; m_aold = 0; m_cnt = 0; m_valid = 0; m_done = 0;

        // Reset, then activity in IDLE that must be ignored
        applyStimulus(1, 0, 2'b00, 0);
        applyStimulus(1, 0, 2'b00, 0);
        applyStimulus(0, 0, 2'b11, 1);
        applyStimulus(0, 0, 2'b01, 1);
        applyStimulus(0, 1, 2'b00, 0);

        // Walk to (1,3) with some results, stall, then resume on p1_En=10
        applyStimulus(0, 0, 2'b01, 1);
        applyStimulus(0, 0, 2'b01, 0);
        applyStimulus(0, 0, 2'b01, 1);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 2'b00, 0);
        applyStimulus(0, 0, 2'b10, 0);
        applyStimulus(0, 0, 2'b01, 1);
        applyStimulus(0, 0, 2'b01, 0);
        applyStimulus(0, 0, 2'b01, 0);
        applyStimulus(0, 0, 2'b01, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 2'b11, 1);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 2'b11, 1);

        // Clear wins over simultaneous advance and result at pair (1,2)
        applyStimulus(0, 1, 2'b00, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 2'b01, i[0]);
        applyStimulus(0, 1, 2'b11, 1);

        // Reset at (0,1) with two results counted, then ignored advances
        applyStimulus(0, 0, 2'b01, 1);
        applyStimulus(0, 0, 2'b01, 1);
        applyStimulus(1, 0, 2'b00, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 2'b11, 1);
        applyStimulus(0, 1, 2'b00, 0);

        for (int i = 0; i < 3000; i++)
            applyStimulus(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
                          2'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0));

        budget = 10;
        while (sb.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        @(posedge clk);
        if (sb.size() != 0) begin
            n_miscompares++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
